// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the iterative multiplier: FSM state encoding and
// counter sizing. The same encoding is intended for a future iterative divider.
package shift_add_multiplier_pkg;

    // The fourth code is unused and recovers to S_IDLE.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } mul_state_e;

    localparam int MIN_WIDTH = 2;

    // Bits needed to count 0..width-1.
    function automatic int cnt_width(input int width);
        return (width <= MIN_WIDTH) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/RippleCarryAdder.sv
// N-bit ripple-carry adder: a + b -> N+1-bit sum, with the carry-out kept in the MSB.
module RippleCarryAdder #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N:0]   sum
);

    logic [N:0] carry;

    always_comb begin
        carry = '0;
        sum   = '0;
        for (int i = 0; i < N; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        sum[N] = carry[N];
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// Iterative WIDTH x WIDTH unsigned shift-add multiplier with a start/busy/done
// handshake; one partial product is accumulated per RUN cycle.
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mul_state_e           state_q;
    mul_state_e           state_d;
    logic [WIDTH-1:0]     mcand_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [CNT_W-1:0]     count_q;
    logic [2*WIDTH-1:0]   product_q;
    logic                 done_q;

    logic [WIDTH-1:0]     acc_hi;
    logic [WIDTH-1:0]     addend;
    logic [WIDTH:0]       sum;

    // Upper half of acc holds the running partial sum, lower half the
    // multiplier bits still to be consumed (LSB first).
    assign acc_hi = acc_q[2*WIDTH-1:WIDTH];
    assign addend = acc_q[0] ? mcand_q : '0;

    RippleCarryAdder #(
        .N(WIDTH)
    ) u_adder (
        .a  (acc_hi),
        .b  (addend),
        .sum(sum)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (count_q == CNT_LAST) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Carry re-enters at the MSB as the whole accumulator shifts right.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q   <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= (state_q == S_DONE);
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mcand_q <= a;
                        acc_q   <= {{WIDTH{1'b0}}, b};
                        count_q <= '0;
                    end
                end
                S_RUN: begin
                    acc_q   <= {sum, acc_q[WIDTH-1:1]};
                    count_q <= count_q + 1'b1;
                end
                S_DONE: begin
                    product_q <= acc_q;
                end
                default: ;
            endcase
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed and random checks for the shift-add multiplier at WIDTH=8 and WIDTH=4.
module tb_shift_add_multiplier;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        start8;
    logic [7:0]  a8, b8;
    logic        busy8, done8;
    logic [15:0] product8;

    logic        start4;
    logic [3:0]  a4, b4;
    logic        busy4, done4;
    logic [7:0]  product4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    shift_add_multiplier #(.WIDTH(8)) u_dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start8),
        .a      (a8),
        .b      (b8),
        .busy   (busy8),
        .done   (done8),
        .product(product8)
    );

    shift_add_multiplier #(.WIDTH(4)) u_dut4 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start4),
        .a      (a4),
        .b      (b4),
        .busy   (busy4),
        .done   (done4),
        .product(product4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One WIDTH=8 operation: start accepted at edge k, done expected at edge k+9.
    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] exp, input string tag);
        int early;
        early = 0;
        @(negedge clk);
        a8 = a; b8 = b; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = ~a; b8 = 8'h5A;
        check({tag, ".busy_rise"}, 32'(busy8), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            early += int'(done8);
        end
        check({tag, ".early_done"}, 32'(early), 32'd0);
        @(posedge clk); #1;
        check({tag, ".done"}, 32'(done8), 32'd1);
        check({tag, ".product"}, 32'(product8), 32'(exp));
        check({tag, ".busy_idle"}, 32'(busy8), 32'd0);
        @(posedge clk); #1;
        check({tag, ".done_drop"}, 32'(done8), 32'd0);
    endtask

    // One WIDTH=4 operation: done expected at edge k+5.
    task automatic op4(input logic [3:0] a, input logic [3:0] b,
                       input logic [7:0] exp, input string tag);
        int early;
        early = 0;
        @(negedge clk);
        a4 = a; b4 = b; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0; a4 = ~a; b4 = ~b;
        check({tag, ".busy_rise"}, 32'(busy4), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            early += int'(done4);
        end
        check({tag, ".early_done"}, 32'(early), 32'd0);
        @(posedge clk); #1;
        check({tag, ".done"}, 32'(done4), 32'd1);
        check({tag, ".product"}, 32'(product4), 32'(exp));
        @(posedge clk); #1;
        check({tag, ".done_drop"}, 32'(done4), 32'd0);
    endtask

    initial begin
        int          bad;
        int          dcnt;
        logic [7:0]  ra8, rb8;
        logic [3:0]  ra4, rb4;

        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0;
        start4 = 1'b0; a4 = '0; b4 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.busy", 32'(busy8), 32'd0);
        check("reset.done", 32'(done8), 32'd0);
        check("reset.product", 32'(product8), 32'd0);
        check("reset.product4", 32'(product4), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        op8(8'd23, 8'd12, 16'd276, "basic");
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (product8 !== 16'd276 || done8 !== 1'b0) bad++;
        end
        check("hold20", 32'(bad), 32'd0);

        op8(8'd255, 8'd255, 16'd65025, "max");
        op8(8'd0,   8'd77,  16'd0,     "zero_a");
        op8(8'd1,   8'd200, 16'd200,   "one_a");
        op8(8'd200, 8'd1,   16'd200,   "one_b");
        op8(8'd77,  8'd0,   16'd0,     "zero_b");

        // Second start during RUN must be ignored.
        @(negedge clk);
        a8 = 8'd3; b8 = 8'd8; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        dcnt = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            start8 = (i == 4);
            if (i == 4) begin
                a8 = 8'd35; b8 = 8'd71;
            end
            @(posedge clk); #1;
            start8 = 1'b0;
            dcnt += int'(done8);
            if (i == 9) check("overlap.product", 32'(product8), 32'd24);
        end
        check("overlap.done_count", 32'(dcnt), 32'd1);
        check("overlap.product_hold", 32'(product8), 32'd24);

        // Start held high: one result every 10 cycles, one idle cycle between.
        @(negedge clk);
        a8 = 8'd35; b8 = 8'd71; start8 = 1'b1;
        @(posedge clk); #1;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            check("held.done", 32'(done8), 32'(i % 10 == 9));
            check("held.busy", 32'(busy8), 32'(i % 10 != 9));
            if (i % 10 == 9) check("held.product", 32'(product8), 32'd2485);
        end
        @(negedge clk);
        start8 = 1'b0;
        repeat (12) @(posedge clk);

        // Asynchronous reset between edges while in RUN.
        @(negedge clk);
        a8 = 8'd23; b8 = 8'd12; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst.busy", 32'(busy8), 32'd0);
        check("arst.done", 32'(done8), 32'd0);
        check("arst.product", 32'(product8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            dcnt += int'(done8);
        end
        check("arst.no_done", 32'(dcnt), 32'd0);
        op8(8'd8, 8'd8, 16'd64, "after_rst");

        op4(4'd15, 4'd15, 8'd225, "w4_max");
        op4(4'd0,  4'd9,  8'd0,   "w4_zero");

        for (int n = 0; n < 500; n++) begin
            ra8 = 8'($urandom);
            rb8 = 8'($urandom);
            op8(ra8, rb8, 16'(ra8) * 16'(rb8), "rand8");
        end
        for (int n = 0; n < 500; n++) begin
            ra4 = 4'($urandom);
            rb4 = 4'($urandom);
            op4(ra4, rb4, 8'(ra4) * 8'(rb4), "rand4");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
